chacha_block_seq: RTL and testbench

Sequences the full ChaCha20 block function around a single-cycle quarter-round datapath.
- Accepts a 64-byte input state (constants, key, counter, nonce) as a byte stream.
- Runs ROUNDS rounds: alternating column and diagonal passes, one quarter-round per clock.
- Adds the original state (feed-forward) and emits the 64-byte keystream block as a byte stream.
- Sits between the host byte interface and the keystream consumer in the chacha design.

---
 rtl/chacha_pkg.sv | 28 ++
 rtl/chacha_qr_comb.sv | 34 +++
 rtl/chacha_block_seq.sv | 136 +++++++++++++
 tb/tb_chacha_block_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha block sequencer and quarter-round datapath.
package chacha_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ROUND = 2'd1,
    EMIT  = 2'd2
  } state_e;

  localparam int unsigned ROT_A = 16;
  localparam int unsigned ROT_B = 12;
  localparam int unsigned ROT_C = 8;
  localparam int unsigned ROT_D = 7;

  // Word indices per step k = scnt mod 8; element 0 is the rightmost entry.
  // k0..k3 are the column quarter-rounds, k4..k7 the diagonals.
  localparam logic [7:0][3:0] QR_A = {4'd3, 4'd2, 4'd1,  4'd0,  4'd3,  4'd2,  4'd1,  4'd0};
  localparam logic [7:0][3:0] QR_B = {4'd4, 4'd7, 4'd6,  4'd5,  4'd7,  4'd6,  4'd5,  4'd4};
  localparam logic [7:0][3:0] QR_C = {4'd9, 4'd8, 4'd11, 4'd10, 4'd11, 4'd10, 4'd9,  4'd8};
  localparam logic [7:0][3:0] QR_D = {4'd14, 4'd13, 4'd12, 4'd15, 4'd15, 4'd14, 4'd13, 4'd12};

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_qr_comb.sv
// Purely combinational ChaCha quarter-round on four 32-bit words.
module chacha_qr_comb
  import chacha_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  word_t a1, b1, c1, d1;
  word_t a2, b2, c2, d2;

  always_comb begin
    a1 = a_i + b_i;
    d1 = rotl(d_i ^ a1, ROT_A);
    c1 = c_i + d1;
    b1 = rotl(b_i ^ c1, ROT_B);
    a2 = a1 + b1;
    d2 = rotl(d1 ^ a2, ROT_C);
    c2 = c1 + d2;
    b2 = rotl(b1 ^ c2, ROT_D);
  end

  assign a_o = a2;
  assign b_o = b2;
  assign c_o = c2;
  assign d_o = d2;

endmodule

// File: rtl/chacha_block_seq.sv
// ChaCha block function sequencer: byte-serial state load, one quarter-round per
// clock over ROUNDS rounds, then feed-forward add and byte-serial keystream output.
module chacha_block_seq
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int STEPS  = 4 * ROUNDS;
  localparam int SCNT_W = $clog2(STEPS);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STEPS - 1);

  if ((ROUNDS < 2) || ((ROUNDS % 2) != 0)) begin : g_rounds_chk
    $error("chacha_block_seq: ROUNDS must be even and >= 2");
  end

  state_e            state_q, state_d;
  logic [5:0]        bcnt_q, bcnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  word_t             work_q [16];
  word_t             work_d [16];
  word_t             init_q [16];
  word_t             init_d [16];

  logic       in_hs, out_hs;
  logic [2:0] k;
  logic [3:0] ia, ib, ic, id;
  word_t      qa, qb, qc, qd;
  word_t      sum_w;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  assign k  = scnt_q[2:0];
  assign ia = QR_A[k];
  assign ib = QR_B[k];
  assign ic = QR_C[k];
  assign id = QR_D[k];

  chacha_qr_comb u_qr (
    .a_i (work_q[ia]),
    .b_i (work_q[ib]),
    .c_i (work_q[ic]),
    .d_i (work_q[id]),
    .a_o (qa),
    .b_o (qb),
    .c_o (qc),
    .d_o (qd)
  );

  // Feed-forward add happens on the word being emitted, so no extra storage is needed.
  assign sum_w = work_q[bcnt_q[5:2]] + init_q[bcnt_q[5:2]];

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    scnt_d    = scnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_hs) begin
          bcnt_d = bcnt_q + 6'd1;
          if (bcnt_q == 6'd63) state_d = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        if (scnt_q == SCNT_LAST) begin
          scnt_d  = '0;
          state_d = EMIT;
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = sum_w[{bcnt_q[1:0], 3'b000} +: 8];
        if (out_hs) begin
          bcnt_d = bcnt_q + 6'd1;
          if (bcnt_q == 6'd63) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    work_d = work_q;
    init_d = init_q;
    if ((state_q == LOAD) && in_hs) begin
      work_d[bcnt_q[5:2]][{bcnt_q[1:0], 3'b000} +: 8] = in_data;
      init_d[bcnt_q[5:2]][{bcnt_q[1:0], 3'b000} +: 8] = in_data;
    end else if (state_q == ROUND) begin
      work_d[ia] = qa;
      work_d[ib] = qb;
      work_d[ic] = qc;
      work_d[id] = qd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      bcnt_q  <= '0;
      scnt_q  <= '0;
      for (int i = 0; i < 16; i++) begin
        work_q[i] <= '0;
        init_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      for (int i = 0; i < 16; i++) begin
        work_q[i] <= work_d[i];
        init_q[i] <= init_d[i];
      end
    end
  end

endmodule

// File: tb/tb_chacha_block_seq.sv
// Scoreboard bench for chacha_block_seq (ROUNDS=20 and ROUNDS=8) and chacha_qr_comb.
module tb_chacha_block_seq;

  typedef logic [15:0][31:0] st_t;
  typedef logic [63:0][7:0]  ks_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROUNDS=20 instance
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready, busy;

  chacha_block_seq #(.ROUNDS(20)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  // ROUNDS=8 instance
  logic       d8_rst_n;
  logic [7:0] d8_in_data;
  logic       d8_in_valid, d8_in_ready;
  logic [7:0] d8_out_data;
  logic       d8_out_valid, d8_out_ready, d8_busy;

  chacha_block_seq #(.ROUNDS(8)) u_dut8 (
    .clk(clk), .rst_n(d8_rst_n), .in_data(d8_in_data), .in_valid(d8_in_valid),
    .in_ready(d8_in_ready), .out_data(d8_out_data), .out_valid(d8_out_valid),
    .out_ready(d8_out_ready), .busy(d8_busy)
  );

  // Standalone quarter-round
  logic [31:0] qa_i, qb_i, qc_i, qd_i, qa_o, qb_o, qc_o, qd_o;
  chacha_qr_comb u_qr (
    .a_i(qa_i), .b_i(qb_i), .c_i(qc_i), .d_i(qd_i),
    .a_o(qa_o), .b_o(qb_o), .c_o(qc_o), .d_o(qd_o)
  );

  logic [7:0] exp_q [$];
  logic [7:0] exp8_q [$];
  bit  stall_en = 1'b0;
  bit  armed = 1'b0, armed8 = 1'b0;
  bit  d8_done = 1'b0;
  int  last_load = 0, last_load8 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic st_t qr_m(input st_t xi, input int a, input int b, input int c, input int d);
    st_t x = xi;
    x[a] = x[a] + x[b]; x[d] = x[d] ^ x[a]; x[d] = {x[d][15:0], x[d][31:16]};
    x[c] = x[c] + x[d]; x[b] = x[b] ^ x[c]; x[b] = {x[b][19:0], x[b][31:20]};
    x[a] = x[a] + x[b]; x[d] = x[d] ^ x[a]; x[d] = {x[d][23:0], x[d][31:24]};
    x[c] = x[c] + x[d]; x[b] = x[b] ^ x[c]; x[b] = {x[b][24:0], x[b][31:25]};
    return x;
  endfunction

  function automatic ks_t block_m(input st_t s, input int rounds);
    st_t x = s;
    ks_t ks;
    logic [31:0] w;
    for (int r = 0; r < rounds / 2; r++) begin
      x = qr_m(x, 0, 4, 8, 12); x = qr_m(x, 1, 5, 9, 13);
      x = qr_m(x, 2, 6, 10, 14); x = qr_m(x, 3, 7, 11, 15);
      x = qr_m(x, 0, 5, 10, 15); x = qr_m(x, 1, 6, 11, 12);
      x = qr_m(x, 2, 7, 8, 13); x = qr_m(x, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) begin
      w = x[i] + s[i];
      for (int j = 0; j < 4; j++) ks[4*i+j] = w[8*j +: 8];
    end
    return ks;
  endfunction

  function automatic st_t mk_state(input logic [31:0] ctr);
    st_t s;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b0;
      b0 = 8'(4 * i);
      s[4+i] = {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    end
    s[12] = ctr; s[13] = 32'h09000000; s[14] = 32'h4a000000; s[15] = 32'h00000000;
    return s;
  endfunction

  // RFC 7539 2.3.2 keystream words, hand-copied
  task automatic push_rfc();
    st_t w;
    w = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
         32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
         32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
         32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++) exp_q.push_back(w[i][8*j +: 8]);
  endtask

  task automatic push_ks(input ks_t ks);
    for (int i = 0; i < 64; i++) exp_q.push_back(ks[i]);
  endtask

  // Called and returns at posedge+#1.
  task automatic load_block(input st_t s, input bit gaps);
    bit hs;
    int guard;
    for (int i = 0; i < 64; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      in_data  = s[i >> 2][(i & 3) * 8 +: 8];
      in_valid = 1'b1;
      hs = 1'b0;
      guard = 0;
      while (!hs) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk); #1;
        guard++;
        if (!hs && guard > 500) begin
          checks++; errors++;
          $display("FAIL load_timeout: byte %0d not accepted, in_ready %b required 1", i, in_ready);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid  = 1'b0;
    last_load = cyc;
    armed     = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin @(posedge clk); #1; g++; end
    chk({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (in_ready) begin
        errors++;
        $display("FAIL ready_overlap: in_ready %b with out_valid %b, required in_ready 0", in_ready, out_valid);
      end
      if (armed) begin
        chk("latency20", 32'(cyc + 1 - last_load), 32'd81);
        armed = 1'b0;
      end
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got byte %h with no expected byte queued", out_data);
      end else begin
        chk("out_byte20", {24'd0, out_data}, {24'd0, exp_q[0]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (d8_out_valid) begin
      if (armed8) begin
        chk("latency8", 32'(cyc + 1 - last_load8), 32'd33);
        armed8 = 1'b0;
      end
      if (exp8_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out8: got byte %h with no expected byte queued", d8_out_data);
      end else begin
        chk("out_byte8", {24'd0, d8_out_data}, {24'd0, exp8_q[0]});
        if (d8_out_ready) void'(exp8_q.pop_front());
      end
    end
  end

  // ROUNDS=8 stream
  initial begin
    st_t s;
    ks_t ks;
    bit hs;
    int g;
    d8_rst_n = 1'b0; d8_in_valid = 1'b0; d8_in_data = 8'h00; d8_out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    d8_rst_n = 1'b1;
    @(posedge clk); #1;
    s  = mk_state(32'd1);
    ks = block_m(s, 8);
    for (int i = 0; i < 64; i++) exp8_q.push_back(ks[i]);
    for (int i = 0; i < 64; i++) begin
      d8_in_data  = s[i >> 2][(i & 3) * 8 +: 8];
      d8_in_valid = 1'b1;
      hs = 1'b0;
      g = 0;
      while (!hs && g < 500) begin
        @(negedge clk); hs = d8_in_ready;
        @(posedge clk); #1; g++;
      end
    end
    d8_in_valid = 1'b0;
    last_load8  = cyc;
    armed8      = 1'b1;
    g = 0;
    while (exp8_q.size() != 0 && g < 2000) begin @(posedge clk); #1; g++; end
    chk("r8_drain_left", 32'(exp8_q.size()), 32'd0);
    d8_done = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    qa_i = 32'h11111111; qb_i = 32'h01020304; qc_i = 32'h9b8d6f43; qd_i = 32'h01234567;
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("qr_a", qa_o, 32'hea2a92f4);
    chk("qr_b", qb_o, 32'hcb1cf8ce);
    chk("qr_c", qc_o, 32'h4581472e);
    chk("qr_d", qd_o, 32'h5881c4bb);
    rst_n = 1'b1;
    @(posedge clk); #1;

    push_rfc();
    load_block(mk_state(32'd1), 1'b0);
    wait_drain("rfc");

    stall_en = 1'b1;
    push_rfc();
    load_block(mk_state(32'd1), 1'b1);
    wait_drain("stall");
    stall_en = 1'b0;

    push_rfc();
    load_block(mk_state(32'd1), 1'b0);
    repeat (37) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    armed = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_rfc();
    load_block(mk_state(32'd1), 1'b0);
    wait_drain("after_rst");

    push_rfc();
    load_block(mk_state(32'd1), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (120) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain("hold_valid");

    push_ks(block_m(mk_state(32'd1), 20));
    load_block(mk_state(32'd1), 1'b0);
    push_ks(block_m(mk_state(32'd2), 20));
    load_block(mk_state(32'd2), 1'b0);
    wait_drain("b2b");

    g = 0;
    while (!d8_done && g < 3000) begin @(posedge clk); #1; g++; end
    chk("r8_done", {31'd0, d8_done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
